sram_port_arbiter: RTL and testbench

Fixed-priority 2:1 arbiter that merges the instruction-fetch and data-access sram-like request ports onto one shared sram-like memory port. It sits between the pipeline (IF stage on the inst side, EXE/MEM stages on the data side) and the single downstream memory or bus bridge. It records the source of every accepted request in an in-order tag FIFO. Each returning `data_ok`/`rdata` goes back to the master that issued it.

---
 rtl/sram_port_arbiter.sv | 77 +++++++
 tb/tb_sram_port_arbiter.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: fixed-priority 2:1 merge of inst/data sram-like ports onto one memory port
module sram_port_arbiter #(
  parameter int TAG_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam int AW = $clog2(TAG_DEPTH);
  logic                 lock_valid, lock_sel, sel, full, push, pop, head;
  logic [TAG_DEPTH-1:0] tags;
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  always_comb begin
    // a locked master keeps the port only while it still requests; otherwise data wins (also when idle)
    sel = (lock_valid && (lock_sel ? data_sram_req : inst_sram_req)) ? lock_sel : (data_sram_req | ~inst_sram_req);
    full = count == (AW+1)'(TAG_DEPTH);
    mem_req = ~reset & ~full & (sel ? data_sram_req : inst_sram_req);
    mem_wr = sel ? data_sram_wr : inst_sram_wr;
    mem_size = sel ? data_sram_size : inst_sram_size;
    mem_addr = sel ? data_sram_addr : inst_sram_addr;
    mem_wstrb = sel ? data_sram_wstrb : inst_sram_wstrb;
    mem_wdata = sel ? data_sram_wdata : inst_sram_wdata;
    push = mem_req & mem_addr_ok;
    pop = ~reset & mem_data_ok & (count != '0);
    head = tags[rd_ptr];
    data_sram_addr_ok = push & sel;
    inst_sram_addr_ok = push & ~sel;
    data_sram_data_ok = pop & head;
    inst_sram_data_ok = pop & ~head;
    inst_sram_rdata = mem_rdata;
    data_sram_rdata = mem_rdata;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_sel <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      lock_valid <= mem_req & ~mem_addr_ok;
      lock_sel <= sel;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk)
    if (push) tags[wr_ptr] <= sel;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed stimulus with a response scoreboard checked by a separate monitor
module tb_sram_port_arbiter;
  logic clk = 0, reset;
  logic inst_sram_req, inst_sram_wr, inst_sram_addr_ok, inst_sram_data_ok;
  logic [1:0] inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata, inst_sram_rdata;
  logic [3:0] inst_sram_wstrb;
  logic data_sram_req, data_sram_wr, data_sram_addr_ok, data_sram_data_ok;
  logic [1:0] data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] data_sram_wstrb;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  typedef struct packed { logic side; logic [31:0] rdata; } exp_t;
  exp_t sbq[$];
  logic [31:0] rd_plan[$];
  int total = 0, pass = 0;

  sram_port_arbiter #(.TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
    .data_sram_addr(data_sram_addr), .data_sram_wstrb(data_sram_wstrb), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h at %0t", n, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_sram_req = 0; data_sram_req = 0; inst_sram_wr = 0; data_sram_wr = 0;
    mem_addr_ok = 0; mem_data_ok = 0;
  endtask

  task automatic req(input logic side, input logic [31:0] a);
    inst_sram_req = ~side; data_sram_req = side; mem_addr_ok = 1;
    if (side) data_sram_addr = a; else inst_sram_addr = a;
  endtask

  task automatic issue(input logic side, input logic [31:0] rd);
    sbq.push_back('{side: side, rdata: rd});
    rd_plan.push_back(rd);
  endtask

  task automatic ret();
    mem_data_ok = 1;
    mem_rdata = (rd_plan.size() != 0) ? rd_plan.pop_front() : 32'h0;
  endtask

  always @(negedge clk)
    if (!reset && (inst_sram_data_ok || data_sram_data_ok)) begin
      if (sbq.size() == 0) begin
        total++;
        $display("FAIL unexpected_data_ok: got inst=%b data=%b want none", inst_sram_data_ok, data_sram_data_ok);
      end else begin
        automatic exp_t e = sbq.pop_front();
        chk("route_side", {31'b0, data_sram_data_ok}, {31'b0, e.side});
        chk("route_excl", {31'b0, inst_sram_data_ok & data_sram_data_ok}, 0);
        chk("rdata", e.side ? data_sram_rdata : inst_sram_rdata, e.rdata);
      end
    end

  initial begin
    reset = 1; idle();
    inst_sram_size = 2; data_sram_size = 2; inst_sram_wstrb = 0; data_sram_wstrb = 0;
    inst_sram_addr = 0; data_sram_addr = 32'h55; inst_sram_wdata = 0; data_sram_wdata = 0; mem_rdata = 0;
    // reset: requests and responses must be blocked
    cyc(); data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1; #1;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_addr_ok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    chk("rst_data_ok", {30'b0, inst_sram_data_ok, data_sram_data_ok}, 0);
    chk("rst_mem_addr", mem_addr, 32'h55);
    cyc(); reset = 0; idle();
    // single inst read
    cyc(); req(0, 32'h1C000000); #1;
    chk("t1_mem_req", {31'b0, mem_req}, 1);
    chk("t1_mem_addr", mem_addr, 32'h1C000000);
    chk("t1_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    issue(0, 32'h02800C00);
    cyc(); idle();
    cyc(); ret();
    cyc(); idle();
    // both request: data store wins, inst follows
    cyc(); req(0, 32'h1C000004); data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h00001004;
    data_sram_wstrb = 4'hF; data_sram_wdata = 32'h12345678; #1;
    chk("t2_mem_addr", mem_addr, 32'h00001004);
    chk("t2_mem_wr_strb", {27'b0, mem_wr, mem_wstrb}, 5'h1F);
    chk("t2_mem_wdata", mem_wdata, 32'h12345678);
    chk("t2_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b01);
    issue(1, 32'h0000BEEF);
    cyc(); data_sram_req = 0; data_sram_wr = 0; #1;
    chk("t2_inst_addr", mem_addr, 32'h1C000004);
    chk("t2_inst_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    issue(0, 32'h11111111);
    cyc(); idle(); ret();
    cyc(); ret();
    cyc(); idle();
    // inst stalls; data arriving mid-stall must not steal the port
    cyc(); req(0, 32'h1C000010); mem_addr_ok = 0; data_sram_addr = 32'h2000; #1;
    chk("t3_stall1", mem_addr, 32'h1C000010);
    chk("t3_stall1_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    cyc(); data_sram_req = 1; #1;
    chk("t3_lock2", mem_addr, 32'h1C000010);
    chk("t3_lock2_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    cyc(); #1;
    chk("t3_lock3", mem_addr, 32'h1C000010);
    cyc(); mem_addr_ok = 1; #1;
    chk("t3_hs_addr", mem_addr, 32'h1C000010);
    chk("t3_hs_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    issue(0, 32'h33);
    cyc(); inst_sram_req = 0; #1;
    chk("t3_data_addr", mem_addr, 32'h2000);
    chk("t3_data_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b01);
    issue(1, 32'h44);
    cyc(); idle(); ret();
    cyc(); ret();
    cyc(); idle();
    // fill the tag FIFO, then 5th request waits for a pop
    for (int i = 0; i < 4; i++) begin
      cyc(); req(i[0], 32'h100 + i); #1;
      chk("t4_fill_addr", mem_addr, 32'h100 + i);
      chk("t4_fill_aok", {31'b0, inst_sram_addr_ok | data_sram_addr_ok}, 1);
      issue(i[0], 32'hA + i);
    end
    cyc(); req(0, 32'h1C000100); #1;
    chk("t4_full_req", {31'b0, mem_req}, 0);
    chk("t4_full_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 0);
    cyc(); ret(); #1;
    chk("t4_pop_same_cycle_req", {31'b0, mem_req}, 0);
    cyc(); ret(); #1;
    chk("t4_after_pop_req", {31'b0, mem_req}, 1);
    chk("t4_after_pop_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    issue(0, 32'hE);
    cyc(); inst_sram_req = 0; mem_addr_ok = 0; ret();
    cyc(); ret();
    cyc(); ret();
    cyc(); idle();
    // steady push+pop at count 3 across pointer wrap
    for (int i = 0; i < 3; i++) begin
      cyc(); req(i[0], 32'h300 + i); issue(i[0], 32'h500 + i);
    end
    for (int i = 3; i < 11; i++) begin
      cyc(); req(i[0], 32'h300 + i); ret(); #1;
      chk("t5_req_at3", {31'b0, mem_req & mem_addr_ok}, 1);
      issue(i[0], 32'h500 + i);
    end
    cyc(); idle(); ret();
    cyc(); ret();
    cyc(); ret();
    cyc(); idle();
    // reset with two outstanding, then a stray response
    cyc(); req(0, 32'h1C000200); issue(0, 32'h66);
    cyc(); req(1, 32'h3000); issue(1, 32'h67);
    cyc(); idle(); reset = 1; mem_data_ok = 1; sbq.delete(); rd_plan.delete(); #1;
    chk("t6_rst_data_ok", {30'b0, inst_sram_data_ok, data_sram_data_ok}, 0);
    cyc(); reset = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD; #1;
    chk("t6_stray", {30'b0, inst_sram_data_ok, data_sram_data_ok}, 0);
    cyc(); idle(); req(0, 32'h1C000300); #1;
    chk("t6_next_req", {31'b0, mem_req}, 1);
    chk("t6_next_aok", {30'b0, inst_sram_addr_ok, data_sram_addr_ok}, 2'b10);
    issue(0, 32'h77);
    cyc(); idle(); ret();
    cyc(); idle();
    cyc();
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
